// File: rtl/fp_dot_accumulator.sv
// Sequential FP32 dot-product accumulator: align/add/normalize per product, valid/ready in and out.
// Build option: define ROUND_NEAREST_EN for round-to-nearest-even; default truncates toward zero.
module fp_dot_accumulator #(
  parameter int GUARD_BITS  = 3,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic [31:0]            In_Product,
  input  logic                   In_Valid,
  input  logic                   In_Last,
  output logic                   In_Ready,
  output logic [31:0]            Out_Sum,
  output logic [COUNT_WIDTH-1:0] Out_Count,
  output logic                   Out_Valid,
  input  logic                   Out_Ready
);

  localparam int W    = 24 + GUARD_BITS;
  localparam int LZ_W = $clog2(W + 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ALIGN = 3'd1;
  localparam logic [2:0] ADD   = 3'd2;
  localparam logic [2:0] NORM  = 3'd3;
  localparam logic [2:0] OUT   = 3'd4;

  logic [2:0]             state_r;
  logic [31:0]            prod_r;
  logic                   last_r;
  logic [31:0]            acc_r;
  logic [COUNT_WIDTH-1:0] count_r;
  logic                   in_ready_r;
  logic                   out_valid_r;
  logic [31:0]            out_sum_r;
  logic [COUNT_WIDTH-1:0] out_count_r;
  logic [W-1:0]           big_sig_r;
  logic [W-1:0]           small_sig_r;
  logic [7:0]             ref_exp_r;
  logic                   sign_r;
  logic                   sub_r;
  logic                   special_r;
  logic [31:0]            special_val_r;
  logic [W:0]             sum_r;

  function automatic logic [LZ_W-1:0] lzc(input logic [W-1:0] v);
    logic [LZ_W-1:0] n;
    logic            found;
    n     = '0;
    found = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      if (!found) begin
        if (v[i]) found = 1'b1;
        else      n = n + LZ_W'(1);
      end
    end
    return n;
  endfunction

  logic [30:0]  acc_mag_s, prod_mag_s;
  logic [W-1:0] acc_sig_s, prod_sig_s, big_sig_s, small_sig_s, small_al_s, lost_mask_s;
  logic [7:0]   big_exp_s, small_exp_s, diff_s;
  logic         big_sign_s, small_sign_s;
  logic         acc_nan_s, acc_inf_s, special_s;
  logic [31:0]  special_val_s;

  // Alignment: pick the larger magnitude as reference, shift the other with sticky, detect Inf/NaN
  always_comb begin
    acc_mag_s  = (acc_r[30:23]  == 8'd0) ? 31'd0 : acc_r[30:0];
    prod_mag_s = (prod_r[30:23] == 8'd0) ? 31'd0 : prod_r[30:0];
    acc_sig_s  = (acc_r[30:23]  == 8'd0) ? '0 : {1'b1, acc_r[22:0],  {GUARD_BITS{1'b0}}};
    prod_sig_s = (prod_r[30:23] == 8'd0) ? '0 : {1'b1, prod_r[22:0], {GUARD_BITS{1'b0}}};
    if (prod_mag_s > acc_mag_s) begin
      big_sig_s    = prod_sig_s;
      big_exp_s    = prod_mag_s[30:23];
      big_sign_s   = prod_r[31];
      small_sig_s  = acc_sig_s;
      small_exp_s  = acc_mag_s[30:23];
      small_sign_s = acc_r[31];
    end else begin
      big_sig_s    = acc_sig_s;
      big_exp_s    = acc_mag_s[30:23];
      big_sign_s   = acc_r[31];
      small_sig_s  = prod_sig_s;
      small_exp_s  = prod_mag_s[30:23];
      small_sign_s = prod_r[31];
    end
    diff_s      = big_exp_s - small_exp_s;
    lost_mask_s = ~({W{1'b1}} << diff_s);
    if (32'(diff_s) >= W) begin
      small_al_s = {{(W-1){1'b0}}, |small_sig_s};
    end else begin
      small_al_s = (small_sig_s >> diff_s) | {{(W-1){1'b0}}, |(small_sig_s & lost_mask_s)};
    end

    acc_nan_s     = (acc_r[30:23] == 8'hFF) && (acc_r[22:0] != 23'd0);
    acc_inf_s     = (acc_r[30:23] == 8'hFF) && (acc_r[22:0] == 23'd0);
    special_s     = 1'b0;
    special_val_s = 32'd0;
    if (acc_nan_s) begin
      special_s     = 1'b1;
      special_val_s = 32'h7FC0_0000;
    end else if (prod_r[30:23] == 8'hFF) begin
      special_s = 1'b1;
      if (acc_inf_s && (acc_r[31] != prod_r[31])) special_val_s = 32'h7FC0_0000;
      else                                        special_val_s = {prod_r[31], 8'hFF, 23'd0};
    end else if (acc_inf_s) begin
      special_s     = 1'b1;
      special_val_s = acc_r;
    end else begin
      special_s     = 1'b0;
      special_val_s = 32'd0;
    end
  end

  logic [W-1:0]    norm_s;
  logic            lost_s;
  logic [9:0]      exp_s;
  logic [22:0]     frac_s;
  logic [LZ_W-1:0] lz_s;
  logic [31:0]     acc_next_s;
`ifdef ROUND_NEAREST_EN
  logic [23:0]     frac_inc_s;
  logic            round_up_s;
`else
  logic            unused_round_s;
  assign unused_round_s = ^{norm_s[GUARD_BITS-1:0], lost_s};
`endif

  // Normalization; exp_s is 10 bits so an underflow shows up as a set bit 9
  always_comb begin
    lz_s = lzc(sum_r[W-1:0]);
    if (sum_r[W]) begin
      norm_s = sum_r[W:1];
      lost_s = sum_r[0];
      exp_s  = {2'b00, ref_exp_r} + 10'd1;
    end else begin
      norm_s = sum_r[W-1:0] << lz_s;
      lost_s = 1'b0;
      exp_s  = {2'b00, ref_exp_r} - 10'(lz_s);
    end
    frac_s = norm_s[W-2:GUARD_BITS];
`ifdef ROUND_NEAREST_EN
    round_up_s = norm_s[GUARD_BITS-1] &&
                 ((|norm_s[GUARD_BITS-2:0]) || lost_s || frac_s[0]);
    frac_inc_s = {1'b0, frac_s} + 24'd1;
    if (round_up_s) begin
      frac_s = frac_inc_s[22:0];
      exp_s  = exp_s + {9'd0, frac_inc_s[23]};
    end else begin
      frac_s = norm_s[W-2:GUARD_BITS];
    end
`endif
    if (special_r)                         acc_next_s = special_val_r;
    else if (!norm_s[W-1])                 acc_next_s = 32'd0;
    else if (exp_s[9] || exp_s == 10'd0)   acc_next_s = 32'd0;
    else if (exp_s >= 10'd255)             acc_next_s = {sign_r, 8'hFF, 23'd0};
    else                                   acc_next_s = {sign_r, exp_s[7:0], frac_s};
  end

  // Control FSM plus all pipeline, accumulator and output registers
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_r       <= IDLE;
      prod_r        <= 32'd0;
      last_r        <= 1'b0;
      acc_r         <= 32'd0;
      count_r       <= '0;
      in_ready_r    <= 1'b0;
      out_valid_r   <= 1'b0;
      out_sum_r     <= 32'd0;
      out_count_r   <= '0;
      big_sig_r     <= '0;
      small_sig_r   <= '0;
      ref_exp_r     <= 8'd0;
      sign_r        <= 1'b0;
      sub_r         <= 1'b0;
      special_r     <= 1'b0;
      special_val_r <= 32'd0;
      sum_r         <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (In_Valid && in_ready_r) begin
            prod_r     <= In_Product;
            last_r     <= In_Last;
            count_r    <= count_r + COUNT_WIDTH'(1);
            in_ready_r <= 1'b0;
            state_r    <= ALIGN;
          end else begin
            in_ready_r <= 1'b1;
          end
        end
        ALIGN: begin
          big_sig_r     <= big_sig_s;
          small_sig_r   <= small_al_s;
          ref_exp_r     <= big_exp_s;
          sign_r        <= big_sign_s;
          sub_r         <= big_sign_s ^ small_sign_s;
          special_r     <= special_s;
          special_val_r <= special_val_s;
          state_r       <= ADD;
        end
        ADD: begin
          if (sub_r) sum_r <= {1'b0, big_sig_r} - {1'b0, small_sig_r};
          else       sum_r <= {1'b0, big_sig_r} + {1'b0, small_sig_r};
          state_r <= NORM;
        end
        NORM: begin
          acc_r <= acc_next_s;
          if (last_r) begin
            out_sum_r   <= acc_next_s;
            out_count_r <= count_r;
            out_valid_r <= 1'b1;
            state_r     <= OUT;
          end else begin
            in_ready_r <= 1'b1;
            state_r    <= IDLE;
          end
        end
        OUT: begin
          if (Out_Ready) begin
            acc_r       <= 32'd0;
            count_r     <= '0;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= IDLE;
          end else begin
            out_valid_r <= 1'b1;
          end
        end
        default: begin
          state_r     <= IDLE;
          in_ready_r  <= 1'b0;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign In_Ready  = in_ready_r;
  assign Out_Valid = out_valid_r;
  assign Out_Sum   = out_sum_r;
  assign Out_Count = out_count_r;

endmodule

// File: tb/tb_fp_dot_accumulator.sv
// Directed, table-driven bench for fp_dot_accumulator with hand-computed FP32 results.
module tb_fp_dot_accumulator;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [31:0] In_Product;
  logic        In_Valid;
  logic        In_Last;
  logic        In_Ready;
  logic [31:0] Out_Sum;
  logic [15:0] Out_Count;
  logic        Out_Valid;
  logic        Out_Ready;

  int checks   = 0;
  int failures = 0;

  fp_dot_accumulator #(.GUARD_BITS(3), .COUNT_WIDTH(16)) dut (
    .Clk(Clk), .Rst(Rst),
    .In_Product(In_Product), .In_Valid(In_Valid), .In_Last(In_Last), .In_Ready(In_Ready),
    .Out_Sum(Out_Sum), .Out_Count(Out_Count), .Out_Valid(Out_Valid), .Out_Ready(Out_Ready)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    string            name;
    int               n;
    logic [3:0][31:0] p;
    logic [31:0]      sum;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic add_vec(input string nm, input int n, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] c, input logic [31:0] s);
    vec_t v;
    v.name = nm;
    v.n    = n;
    v.p    = {32'd0, c, b, a};
    v.sum  = s;
    vecs.push_back(v);
  endtask

  // Returns on the falling edge after the accepting rising edge
  task automatic send(input logic [31:0] p, input logic last);
    int w = 0;
    while (!In_Ready && w < 50) begin
      @(negedge Clk);
      w++;
    end
    if (!In_Ready) chk("send_ready_timeout", {31'd0, In_Ready}, 32'd1);
    In_Product = p;
    In_Last    = last;
    In_Valid   = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    In_Valid = 1'b0;
    In_Last  = 1'b0;
  endtask

  // Called right after the Last send: counts edges from the handshake edge
  task automatic wait_out(input string nm, input logic [31:0] exp_sum, input logic [15:0] exp_cnt);
    int lat = 1;
    while (!Out_Valid && lat < 20) begin
      @(posedge Clk);
      @(negedge Clk);
      lat++;
    end
    chk({nm, "_latency"}, 32'(lat), 32'd4);
    chk({nm, "_sum"}, Out_Sum, exp_sum);
    chk({nm, "_count"}, {16'd0, Out_Count}, {16'd0, exp_cnt});
  endtask

  task automatic accept_out(input string nm);
    Out_Ready = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    Out_Ready = 1'b0;
    chk({nm, "_valid_drop"}, {31'd0, Out_Valid}, 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] round_exp;
`ifdef ROUND_NEAREST_EN
    round_exp = 32'h4B80_0001;
`else
    round_exp = 32'h4B80_0000;
`endif
    add_vec("sum123",    3, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000);
    add_vec("cancel",    2, 32'h3FC0_0000, 32'hBFC0_0000, 32'd0,         32'h0000_0000);
    add_vec("overflow",  2, 32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'd0,         32'h7F80_0000);
    add_vec("inf_nan",   2, 32'h7F80_0000, 32'hFF80_0000, 32'd0,         32'h7FC0_0000);
    add_vec("nan_stick", 3, 32'h7F80_0000, 32'hFF80_0000, 32'h3F80_0000, 32'h7FC0_0000);
    add_vec("inf_fin",   2, 32'hFF80_0000, 32'h4200_0000, 32'd0,         32'hFF80_0000);
    add_vec("tie",       2, 32'h4B80_0000, 32'h3F80_0000, 32'd0,         32'h4B80_0000);
    add_vec("round",     2, 32'h4B80_0000, 32'h3FC0_0000, 32'd0,         round_exp);
    add_vec("single",    1, 32'h4049_0FDB, 32'd0,         32'd0,         32'h4049_0FDB);
    add_vec("denorm",    2, 32'h0000_0001, 32'h3F80_0000, 32'd0,         32'h3F80_0000);
    add_vec("sub_norm",  2, 32'h3F80_0000, 32'hBF40_0000, 32'd0,         32'h3E80_0000);
    add_vec("mixed",     3, 32'h4120_0000, 32'hC040_0000, 32'h3F00_0000, 32'h40F0_0000);

    Rst = 1'b1; In_Valid = 1'b0; In_Product = 32'd0; In_Last = 1'b0; Out_Ready = 1'b0;
    repeat (3) @(negedge Clk);
    chk("reset_in_ready",  {31'd0, In_Ready},  32'd0);
    chk("reset_out_valid", {31'd0, Out_Valid}, 32'd0);
    chk("reset_out_sum",   Out_Sum,            32'd0);
    chk("reset_out_count", {16'd0, Out_Count}, 32'd0);
    Rst = 1'b0;
    @(negedge Clk);
    chk("ready_after_reset", {31'd0, In_Ready}, 32'd1);

    for (int i = 0; i < vecs.size(); i++) begin
      for (int k = 0; k < vecs[i].n; k++) send(vecs[i].p[k], (k == vecs[i].n - 1));
      wait_out(vecs[i].name, vecs[i].sum, 16'(vecs[i].n));
      accept_out(vecs[i].name);
    end

    // Output back-pressure: result held, input blocked, pulses ignored
    send(32'h4040_0000, 1'b1);
    wait_out("bp", 32'h4040_0000, 16'd1);
    for (int c = 0; c < 5; c++) begin
      In_Valid   = (c % 2 == 0);
      In_Product = 32'h4000_0000;
      In_Last    = 1'b1;
      @(posedge Clk);
      @(negedge Clk);
      chk("bp_hold_sum",   Out_Sum,            32'h4040_0000);
      chk("bp_hold_count", {16'd0, Out_Count}, 32'd1);
      chk("bp_in_ready",   {31'd0, In_Ready},  32'd0);
      chk("bp_out_valid",  {31'd0, Out_Valid}, 32'd1);
    end
    In_Valid = 1'b0;
    In_Last  = 1'b0;
    accept_out("bp");
    send(32'h3F80_0000, 1'b1);
    wait_out("bp_after", 32'h3F80_0000, 16'd1);
    accept_out("bp_after");

    // Reset while the second product of a vector is in ADD
    send(32'h3F80_0000, 1'b0);
    send(32'h4000_0000, 1'b0);
    @(posedge Clk);
    @(negedge Clk);
    Rst = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    chk("midrst_in_ready",  {31'd0, In_Ready},  32'd0);
    chk("midrst_out_valid", {31'd0, Out_Valid}, 32'd0);
    chk("midrst_out_sum",   Out_Sum,            32'd0);
    chk("midrst_out_count", {16'd0, Out_Count}, 32'd0);
    Rst = 1'b0;
    send(32'h3F80_0000, 1'b1);
    wait_out("post_rst", 32'h3F80_0000, 16'd1);
    accept_out("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
